// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: mode/set controller for the watch time datapath.
// Steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN on btn_mode rises, emits one-cycle
// increment pulses for the selected field on btn_up rises, freezes the divider while setting,
// and blinks the selected field. Idle SET states time out back to RUN.
// Optional feature macro: WATCH_SET_CTRL_AUTO_REPEAT_EN (hold-to-repeat on btn_up).
module watch_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
`ifdef WATCH_SET_CTRL_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 50_000_000,
  parameter int unsigned REPEAT_PERIOD  = 10_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       o_run,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic [1:0] o_sel,
  output logic       o_blink
);

  localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BlinkW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [BlinkW-1:0]   BlinkLast   = BlinkW'(BLINK_CYCLES - 1);

  // Encoding doubles as the o_sel field code.
  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10,
    StSetSec  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic btn_mode_q, btn_up_q;
  logic mode_rise, up_rise, in_set, rep_pulse, expire, up_evt;
  logic [TimeoutW-1:0] timeout_q, timeout_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic blink_q, blink_d, run_q, run_d;
  logic sec_inc_q, sec_inc_d, min_inc_q, min_inc_d, hour_inc_q, hour_inc_d;

  assign mode_rise = btn_mode & ~btn_mode_q;
  assign up_rise   = btn_up & ~btn_up_q;
  assign in_set    = (state_q != StRun);

  // Timeout fires only when no button activity lands in the same cycle.
  assign expire = in_set & (timeout_q == TimeoutLast) & ~mode_rise & ~up_rise & ~rep_pulse;

`ifdef WATCH_SET_CTRL_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic rep_phase_q, rep_phase_d, rep_hold;

  // Held (not freshly risen) in a SET state; a mode rise aborts the repeat.
  assign rep_hold = in_set & btn_up & btn_up_q & ~mode_rise;

  // Repeat pulse at the end of the initial delay, then at each period end
  always_comb begin
    rep_pulse = 1'b0;
    if (rep_hold) begin
      rep_pulse = (rep_cnt_q == (rep_phase_q ? RepPeriodLast : RepDelayLast));
    end
  end

  // Repeat counter advances while held, clears on release, mode rise or leaving SET
  always_comb begin
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    if (rep_hold && !expire) begin
      if (rep_pulse) begin
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_cnt_q + 1'b1;
        rep_phase_d = rep_phase_q;
      end
    end
  end

  // Repeat state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  // Next state: mode rise advances, idle timeout returns to RUN
  always_comb begin
    state_d = state_q;
    if (mode_rise) begin
      case (state_q)
        StRun:     state_d = StSetHour;
        StSetHour: state_d = StSetMin;
        StSetMin:  state_d = StSetSec;
        default:   state_d = StRun;
      endcase
    end else if (expire) begin
      state_d = StRun;
    end
  end

  // Timeout and blink counter next-state
  always_comb begin
    if (!in_set || mode_rise || up_rise || rep_pulse || expire) begin
      timeout_d = '0;
    end else begin
      timeout_d = timeout_q + 1'b1;
    end

    if (state_d == StRun || mode_rise) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_d     = blink_q;
    end
  end

  // Output next-state: inc pulse routed to the selected field, mode rise suppresses it
  always_comb begin
    up_evt     = (up_rise | rep_pulse) & ~mode_rise;
    hour_inc_d = up_evt & (state_q == StSetHour);
    min_inc_d  = up_evt & (state_q == StSetMin);
    sec_inc_d  = up_evt & (state_q == StSetSec);
    run_d      = (state_d == StRun);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Edge-detect, counter and registered-output state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_mode_q  <= 1'b0;
      btn_up_q    <= 1'b0;
      timeout_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      run_q       <= 1'b1;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
    end else begin
      btn_mode_q  <= btn_mode;
      btn_up_q    <= btn_up;
      timeout_q   <= timeout_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      run_q       <= run_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
    end
  end

  assign o_sel      = state_q;
  assign o_run      = run_q;
  assign o_blink    = blink_q;
  assign o_sec_inc  = sec_inc_q;
  assign o_min_inc  = min_inc_q;
  assign o_hour_inc = hour_inc_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Testbench for watch_set_ctrl: per-cycle expected outputs are queued when inputs are driven
// and popped/compared one edge later. Honours WATCH_SET_CTRL_AUTO_REPEAT_EN if defined.
module tb_watch_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       o_run, o_sec_inc, o_min_inc, o_hour_inc, o_blink;
  logic [1:0] o_sel;

  watch_set_ctrl #(
    .TIMEOUT_CYCLES(40),
    .BLINK_CYCLES  (4)
`ifdef WATCH_SET_CTRL_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (3)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .o_run     (o_run),
    .o_sec_inc (o_sec_inc),
    .o_min_inc (o_min_inc),
    .o_hour_inc(o_hour_inc),
    .o_sel     (o_sel),
    .o_blink   (o_blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       run;
    logic [2:0] inc;   // {hour, min, sec}
    logic       blink;
    string      name;
  } exp_t;

  typedef struct {
    logic       m;
    logic       u;
    logic [1:0] sel;
    logic [2:0] inc;
    logic       blink;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[24];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input logic [1:0] s, input logic [2:0] inc, input logic b,
                          input string nm);
    exp_t e;
    e.sel   = s;
    e.run   = (s == 2'b00);
    e.inc   = inc;
    e.blink = b;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  task automatic compare_head();
    exp_t       e;
    logic [2:0] inc_act;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    inc_act = {o_hour_inc, o_min_inc, o_sec_inc};
    if (o_sel !== e.sel || o_run !== e.run || inc_act !== e.inc || o_blink !== e.blink) begin
      errors++;
      $display("FAIL %s @%0t: got sel=%b run=%b inc=%b blink=%b, want sel=%b run=%b inc=%b blink=%b",
               e.name, $time, o_sel, o_run, inc_act, o_blink, e.sel, e.run, e.inc, e.blink);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
  task automatic step(input logic m, input logic u, input logic [1:0] s, input logic [2:0] inc,
                      input logic b, input string nm);
    @(negedge clk);
    btn_mode = m;
    btn_up   = u;
    push_exp(s, inc, b, nm);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Mode press: 2 high, 2 low. Entry into any state leaves blink at 1 for 4 cycles.
  task automatic press(input logic [1:0] s, input string nm);
    step(1'b1, 1'b0, s, 3'b000, 1'b1, nm);
    step(1'b1, 1'b0, s, 3'b000, 1'b1, nm);
    step(1'b0, 1'b0, s, 3'b000, 1'b1, nm);
    step(1'b0, 1'b0, s, 3'b000, 1'b1, nm);
  endtask

  // Up tap right after a press: blink has just gone low.
  task automatic up_tap(input logic [1:0] s, input logic [2:0] inc, input string nm);
    step(1'b0, 1'b1, s, inc,    1'b0, nm);
    step(1'b0, 1'b0, s, 3'b000, 1'b0, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_inc;

    // Mode walk table: 4 presses of 2 high / 4 low from RUN.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 6; c++) begin
        vecs[p*6+c].m     = (c < 2);
        vecs[p*6+c].u     = 1'b0;
        vecs[p*6+c].sel   = 2'(p + 1);
        vecs[p*6+c].inc   = 3'b000;
        vecs[p*6+c].blink = (p == 3) ? 1'b1 : (c < 4);
      end
    end

    // Reset and idle
    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(2'b00, 3'b000, 1'b1, "reset_values");
    compare_head();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'b00, 3'b000, 1'b1, "idle_run");

    // Table-driven mode walk
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].m, vecs[i].u, vecs[i].sel, vecs[i].inc, vecs[i].blink, "mode_walk");
    end

    // SET_MIN: up held 10 cycles then released
    press(2'b01, "to_set_hour");
    press(2'b10, "to_set_min");
    for (int j = 0; j < 12; j++) begin
      exp_inc = (j == 0) ? 3'b010 : 3'b000;
`ifdef WATCH_SET_CTRL_AUTO_REPEAT_EN
      if (j == 8) exp_inc = 3'b010;
`endif
      step(1'b0, (j < 10), 2'b10, exp_inc, (((j + 4) / 4) % 2 == 0), "min_up_hold");
    end

    // Per-field increments, then mode+up collision in SET_HOUR
    press(2'b11, "to_set_sec");
    up_tap(2'b11, 3'b001, "sec_up_tap");
    press(2'b00, "back_to_run");
    press(2'b01, "to_set_hour_b");
    up_tap(2'b01, 3'b100, "hour_up_tap");
    step(1'b1, 1'b1, 2'b10, 3'b000, 1'b1, "mode_up_same");
    step(1'b1, 1'b1, 2'b10, 3'b000, 1'b1, "mode_up_same");
    step(1'b0, 1'b0, 2'b10, 3'b000, 1'b1, "mode_up_same");
    step(1'b0, 1'b0, 2'b10, 3'b000, 1'b1, "mode_up_same");

    // SET_SEC idle timeout: back to RUN exactly 40 cycles after entry, blink period 8
    for (int t = 0; t < 44; t++) begin
      step((t < 2), 1'b0, (t < 40) ? 2'b11 : 2'b00, 3'b000,
           (t >= 40) ? 1'b1 : ((t / 4) % 2 == 0), "timeout");
    end

    // Async reset while an up press is pending in SET_HOUR
    press(2'b01, "to_set_hour_c");
    @(negedge clk);
    btn_up = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    push_exp(2'b00, 3'b000, 1'b1, "async_reset");
    compare_head();
    @(posedge clk);
    #1;
    push_exp(2'b00, 3'b000, 1'b1, "reset_held");
    compare_head();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 3'b000, 1'b1, "up_in_run");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b00, 3'b000, 1'b1, "post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
